// File: rtl/lpf_multi.sv
// lpf_multi: vector of independent input debouncers. Each channel has an
// optional input synchroniser, a saturating up/down integrator and a
// ZERO/ONE hysteresis state machine producing a level plus rise/fall pulses.
module lpf_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned FILTER_SIZE = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HI_TH       = (2 ** FILTER_SIZE) - 1,
  parameter int unsigned LO_TH       = 0
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                en,
  input  logic                clear,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out_filt,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int unsigned MAX = (32'd1 << FILTER_SIZE) - 32'd1;

  // Elaboration-time parameter legality
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("lpf_multi: CHANNELS must be in 1..32");
  end
  if (FILTER_SIZE < 1 || FILTER_SIZE > 31) begin : g_bad_filter_size
    $error("lpf_multi: FILTER_SIZE must be in 1..31");
  end
  if (SYNC_STAGES > 3) begin : g_bad_sync
    $error("lpf_multi: SYNC_STAGES must be in 0..3");
  end
  if (HI_TH < 1 || HI_TH > MAX) begin : g_bad_hi
    $error("lpf_multi: HI_TH must be in 1..2^FILTER_SIZE-1");
  end
  if (LO_TH >= HI_TH) begin : g_bad_lo
    $error("lpf_multi: LO_TH must be below HI_TH");
  end

  localparam logic [FILTER_SIZE-1:0] MAX_C = '1;
  localparam logic [FILTER_SIZE-1:0] HI_C  = FILTER_SIZE'(HI_TH);
  localparam logic [FILTER_SIZE-1:0] LO_C  = FILTER_SIZE'(LO_TH);
  localparam logic [FILTER_SIZE-1:0] ONE_C = FILTER_SIZE'(1);

  typedef enum logic {
    ZERO = 1'b0,
    ONE  = 1'b1
  } state_e;

  logic [CHANNELS-1:0]    s_c;
  logic [FILTER_SIZE-1:0] cnt_q   [CHANNELS];
  logic [FILTER_SIZE-1:0] cnt_d   [CHANNELS];
  state_e                 state_q [CHANNELS];
  state_e                 state_d [CHANNELS];
  logic [CHANNELS-1:0]    rise_q, rise_d;
  logic [CHANNELS-1:0]    fall_q, fall_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s_c = in;
  end else begin : g_sync
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    // Synchroniser shift chain; ignores en and clear, cleared only by reset
    always_ff @(posedge clk) begin
      if (resetN) begin
        for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= in;
        for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s_c = sync_q[SYNC_STAGES-1];
  end

  // Next-state: integrator step and hysteresis transitions per channel
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
    end
    rise_d = '0;
    fall_d = '0;

    if (clear) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_d[i]   = '0;
        state_d[i] = ZERO;
      end
    end else if (en) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        // Transition decision uses the counter value before this edge's step
        case (state_q[i])
          ZERO: begin
            if (s_c[i] && (cnt_q[i] >= HI_C)) begin
              state_d[i] = ONE;
              rise_d[i]  = 1'b1;
            end
          end
          ONE: begin
            if (!s_c[i] && (cnt_q[i] <= LO_C)) begin
              state_d[i] = ZERO;
              fall_d[i]  = 1'b1;
            end
          end
          default: state_d[i] = ZERO;
        endcase

        if (s_c[i] && (cnt_q[i] != MAX_C)) begin
          cnt_d[i] = cnt_q[i] + ONE_C;
        end else if (!s_c[i] && (cnt_q[i] != '0)) begin
          cnt_d[i] = cnt_q[i] - ONE_C;
        end
      end
    end
  end

  // State, counter and pulse registers
  always_ff @(posedge clk) begin
    if (resetN) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= ZERO;
      end
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Filtered level is the registered state itself
  always_comb begin
    out_filt = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      out_filt[i] = (state_q[i] == ONE);
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_lpf_multi.sv
// Bench for lpf_multi: one default instance and one hysteresis instance
// (SYNC_STAGES=0, HI_TH=12, LO_TH=3) sharing stimulus, checked every cycle
// against an arithmetic per-channel reference model plus directed checks.
module tb_lpf_multi;

  localparam int NCH = 4;
  localparam int MAXC = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetN, en, clear;
  logic [NCH-1:0] in_v;
  logic [NCH-1:0] a_filt, a_rise, a_fall;
  logic [NCH-1:0] b_filt, b_rise, b_fall;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: [instance][channel]
  int m_cnt [2][NCH];
  bit m_st  [2][NCH];
  bit m_r   [2][NCH];
  bit m_f   [2][NCH];
  bit m_sy  [2][NCH][3];

  lpf_multi dut_a (
    .clk(clk), .resetN(resetN), .en(en), .clear(clear), .in(in_v),
    .out_filt(a_filt), .rise(a_rise), .fall(a_fall)
  );

  lpf_multi #(.SYNC_STAGES(0), .HI_TH(12), .LO_TH(3)) dut_b (
    .clk(clk), .resetN(resetN), .en(en), .clear(clear), .in(in_v),
    .out_filt(b_filt), .rise(b_rise), .fall(b_fall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the specified behaviour to the model
  function automatic void model_edge();
    int sn, hi, lo;
    bit s, ns;
    for (int d = 0; d < 2; d++) begin
      sn = (d == 0) ? 2 : 0;
      hi = (d == 0) ? 15 : 12;
      lo = (d == 0) ? 0 : 3;
      for (int c = 0; c < NCH; c++) begin
        if (sn == 0) s = in_v[c];
        else         s = m_sy[d][c][sn-1];
        if (resetN) begin
          for (int k = 0; k < 3; k++) m_sy[d][c][k] = 1'b0;
          m_cnt[d][c] = 0;
          m_st[d][c]  = 1'b0;
          m_r[d][c]   = 1'b0;
          m_f[d][c]   = 1'b0;
        end else begin
          for (int k = 2; k > 0; k--) m_sy[d][c][k] = m_sy[d][c][k-1];
          m_sy[d][c][0] = in_v[c];
          m_r[d][c] = 1'b0;
          m_f[d][c] = 1'b0;
          if (clear) begin
            m_cnt[d][c] = 0;
            m_st[d][c]  = 1'b0;
          end else if (en) begin
            ns = m_st[d][c];
            if (!m_st[d][c] && s && m_cnt[d][c] >= hi)     ns = 1'b1;
            else if (m_st[d][c] && !s && m_cnt[d][c] <= lo) ns = 1'b0;
            m_r[d][c]  = !m_st[d][c] && ns;
            m_f[d][c]  = m_st[d][c] && !ns;
            m_st[d][c] = ns;
            if (s) m_cnt[d][c] = (m_cnt[d][c] < MAXC) ? m_cnt[d][c] + 1 : m_cnt[d][c];
            else   m_cnt[d][c] = (m_cnt[d][c] > 0) ? m_cnt[d][c] - 1 : m_cnt[d][c];
          end
        end
      end
    end
  endfunction

  task automatic compare_all();
    logic [NCH-1:0] ef [2];
    logic [NCH-1:0] er [2];
    logic [NCH-1:0] eg [2];
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        ef[d][c] = m_st[d][c];
        er[d][c] = m_r[d][c];
        eg[d][c] = m_f[d][c];
      end
    end
    chk("model_a_filt", 32'(a_filt), 32'(ef[0]));
    chk("model_a_rise", 32'(a_rise), 32'(er[0]));
    chk("model_a_fall", 32'(a_fall), 32'(eg[0]));
    chk("model_b_filt", 32'(b_filt), 32'(ef[1]));
    chk("model_b_rise", 32'(b_rise), 32'(er[1]));
    chk("model_b_fall", 32'(b_fall), 32'(eg[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[d][c] = 0; m_st[d][c] = 1'b0; m_r[d][c] = 1'b0; m_f[d][c] = 1'b0;
        for (int k = 0; k < 3; k++) m_sy[d][c][k] = 1'b0;
      end
    resetN = 1'b1; en = 1'b1; clear = 1'b0; in_v = 4'hF;

    // Reset held with inputs high: all outputs stay low
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("reset_filt", 32'(a_filt | b_filt), 32'(0));
      chk("reset_pulses", 32'(a_rise | a_fall | b_rise | b_fall), 32'(0));
    end

    // Rise latency from release with inputs held high
    resetN = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 12) chk("b_filt0_e12", 32'(b_filt[0]), 32'(0));
      if (e == 13) begin
        chk("b_filt0_e13", 32'(b_filt[0]), 32'(1));
        chk("b_rise_e13", 32'(b_rise), 32'(4'hF));
      end
      if (e == 17) chk("a_filt0_e17", 32'(a_filt[0]), 32'(0));
      if (e == 18) begin
        chk("a_filt0_e18", 32'(a_filt[0]), 32'(1));
        chk("a_rise_same_cycle", 32'(a_rise), 32'(4'hF));
      end
      if (e == 19) chk("a_rise_drop_e19", 32'(a_rise), 32'(0));
    end

    // Hysteresis on B and fall latency on A from a saturated counter
    in_v = 4'h0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 12) chk("b_filt0_low12", 32'(b_filt[0]), 32'(1));
      if (e == 13) begin
        chk("b_filt0_low13", 32'(b_filt[0]), 32'(0));
        chk("b_fall0_low13", 32'(b_fall[0]), 32'(1));
      end
      if (e == 14) chk("b_fall_drop", 32'(b_fall), 32'(0));
      if (e == 17) chk("a_filt0_low17", 32'(a_filt[0]), 32'(1));
      if (e == 18) chk("a_fall_low18", 32'(a_fall), 32'(4'hF));
    end
    ticks(5);

    // Glitch rejection on channel 1
    in_v = 4'b0010;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("glitch_a_filt1", 32'(a_filt[1]), 32'(0));
    end
    in_v = 4'h0;
    for (int e = 1; e <= 25; e++) begin
      tick();
      chk("glitch_a_filt1", 32'(a_filt[1]), 32'(0));
      chk("glitch_b_filt1", 32'(b_filt[1]), 32'(0));
    end
    // Counters back at zero: full rise latency again
    in_v = 4'b0010;
    for (int e = 1; e <= 18; e++) begin
      tick();
      chk("post_glitch_a_filt1", 32'(a_filt[1]), 32'(e >= 18));
      chk("post_glitch_b_filt1", 32'(b_filt[1]), 32'(e >= 13));
    end

    // clear together with en: clear wins, no fall pulse
    in_v = 4'h0; clear = 1'b1;
    tick();
    chk("clear_a_filt", 32'(a_filt), 32'(0));
    chk("clear_a_fall", 32'(a_fall), 32'(0));
    chk("clear_b_fall", 32'(b_fall), 32'(0));
    clear = 1'b0;
    ticks(4);

    // Saturation on channel 2, toggling channel 3 never asserts
    for (int e = 1; e <= 100; e++) begin
      in_v = {1'(e & 1), 1'b1, 2'b00};
      tick();
      chk("toggle_a_filt3", 32'(a_filt[3]), 32'(0));
      chk("toggle_b_filt3", 32'(b_filt[3]), 32'(0));
    end
    chk("sat_a_filt2", 32'(a_filt[2]), 32'(1));
    in_v = 4'h0;
    for (int e = 1; e <= 18; e++) begin
      tick();
      chk("sat_fall_a_filt2", 32'(a_filt[2]), 32'(e < 18));
      chk("sat_fall_a_fall2", 32'(a_fall[2]), 32'(e == 18));
    end
    ticks(5);

    // en low for 4 edges mid-rise stretches latency to 22
    in_v = 4'b0001;
    for (int e = 1; e <= 23; e++) begin
      en = (e >= 6 && e <= 9) ? 1'b0 : 1'b1;
      tick();
      chk("en_a_filt0", 32'(a_filt[0]), 32'(e >= 22));
      chk("en_a_rise0", 32'(a_rise[0]), 32'(e == 22));
    end
    en = 1'b1;

    // Single clear pulse while high
    clear = 1'b1;
    tick();
    chk("clear_pulse_a_filt0", 32'(a_filt[0]), 32'(0));
    chk("clear_pulse_a_fall0", 32'(a_fall[0]), 32'(0));
    clear = 1'b0;
    ticks(3);

    // Randomised phase with slowly changing inputs and sparse controls
    for (int e = 0; e < 800; e++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 11) == 0) in_v[c] = ~in_v[c];
      en     = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 149) == 0);
      resetN = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lpf_multi.md
# lpf_multi

Multi-channel, parametrised successor to the single-bit keyboard line filter. Each channel debounces one asynchronous raw input with an optional input synchroniser, a saturating up/down integrator and a hysteresis state machine with separate set and clear thresholds. Each channel produces a filtered level and one-cycle rise and fall pulses. The block sits between the raw key/PS2 pins and the keyboard decoding logic, replacing per-line filter instances with one vector instance.

## Interface
- CHANNELS, 4: number of independent filter channels, 1..32.
- FILTER_SIZE, 4: integrator counter width in bits; MAX = 2^FILTER_SIZE-1.
- SYNC_STAGES, 2: flip-flops in the per-channel input synchroniser, 0..3. 0 means the input is used directly.
- HI_TH, 2^FILTER_SIZE-1: counter level at or above which a ZERO channel may switch to ONE; legal range 1..MAX.
- LO_TH, 0: counter level at or below which a ONE channel may switch to ZERO; legal range 0..HI_TH-1.
- clk  in  1  single clock; all state updates on its rising edge.
- resetN  in  1  reset; synchronous and active-high (1 = reset), sampled on the clk rising edge.
- en  in  1  1 = filters advance; 0 = all counters and states hold.
- clear  in  1  synchronous clear of all counters and states; synchroniser flops are untouched.
- in  in  CHANNELS  raw asynchronous inputs, one bit per channel.
- out_filt  out  CHANNELS  filtered level per channel (registered).
- rise  out  CHANNELS  one-cycle pulse in the first cycle out_filt[i] is 1.
- fall  out  CHANNELS  one-cycle pulse in the first cycle out_filt[i] is 0 after being 1.

## Operation
- Illegal parameters (range violations, LO_TH >= HI_TH) stop elaboration with an error.
- Per channel i, s[i] is the last synchroniser stage, or in[i] when SYNC_STAGES = 0. The synchroniser shifts every cycle, regardless of en or clear.
- Priority on each edge: resetN > clear > en.
  - resetN = 1: synchroniser flops, counters, states, rise and fall all go to 0; every channel's state is ZERO.
  - clear = 1: counters go to 0, states go to ZERO, rise and fall go to 0 (no fall pulse is generated by clear).
  - en = 0: counter and state hold; rise and fall go to 0.
- Counter, when enabled:
  - s = 1 and cnt < MAX: cnt+1.
  - s = 0 and cnt > 0: cnt-1.
  - Otherwise hold. The counter saturates at 0 and MAX and never wraps.
- State machine (ZERO/ONE), evaluated on the registered cnt before the update:
  - ZERO -> ONE when s = 1 and cnt >= HI_TH.
  - ONE -> ZERO when s = 0 and cnt <= LO_TH.
  - Otherwise the state holds.
  - The counter update and the state transition occur on the same edge.
- out_filt[i] = 1 exactly when the state is ONE.
- rise[i] is registered and set on the edge where the state goes ZERO -> ONE. fall[i] is set on the edge where it goes ONE -> ZERO. Both are 0 in all other cycles, so they never assert together.
- Channels are fully independent; simultaneous transitions on several channels are all reported in the same cycle.

## Timing
- Reset values: out_filt = 0, rise = 0, fall = 0, all counters = 0.
- Rise latency from cnt = 0 with input held high: out_filt and rise assert SYNC_STAGES + HI_TH + 1 edges after the first edge that samples in = 1.
  - Defaults: 2 + 15 + 1 = 18 edges.
- Fall latency from cnt = MAX with input held low: SYNC_STAGES + (MAX - LO_TH) + 1 edges.
  - Defaults: 18 edges.
- Any input pulse shorter than HI_TH cycles, starting from cnt = 0, never sets out_filt.
- Cycles with en = 0 stretch the latency by exactly their count.
- resetN or clear during an in-progress count discards it. Counting restarts from 0 on the first cycle after they deassert.
- No combinational path from any input to any output.

## Test plan
- Reset: resetN = 1 for 3 cycles with in = all ones -> out_filt, rise and fall stay 0. After release with in held at 1 and defaults, channel 0's out_filt and rise[0] go high on edge 18 and rise drops on edge 19.
- Glitch rejection: defaults, in[1] high for 5 cycles then low -> out_filt[1] stays 0, and the counter returns to 0 after 5 more cycles.
- Hysteresis: HI_TH = 12, LO_TH = 3, SYNC_STAGES = 0, in[0] held high until out_filt = 1 (edge 13), then low.
  - out_filt[0] and fall[0] go to 0 after exactly 13 low cycles (counter saturated at 15, stepping 15 -> 3, then transition).
- Saturation and independence: in[2] high for 100 cycles -> the counter holds at 15 with no wrap. Meanwhile channel 3, toggling every cycle, keeps out_filt[3] = 0 throughout.
- Enable/clear: with en low for 4 cycles mid-rise, assertion moves from edge 18 to edge 22. A single clear pulse while out_filt = 1 forces out_filt = 0 on the next edge with fall = 0.
- Simultaneous events: channels 0 and 1 driven identically -> rise[0] and rise[1] assert in the same cycle. clear and en asserted together -> clear wins.
